// File: rtl/rf_port_arbiter_if.sv
// Two-requester register-file port bundle: request/response handshakes and the RF access bus.
interface rf_port_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
);
   logic              req0_valid;
   logic              req0_we;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic              req0_ready;
   logic              rsp0_valid;
   logic [DATA_W-1:0] rsp0_rdata;

   logic              req1_valid;
   logic              req1_we;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic              req1_ready;
   logic              rsp1_valid;
   logic [DATA_W-1:0] rsp1_rdata;

   logic              rf_wen;
   logic              rf_ren;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_wdata,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      input  rf_rdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output rf_wen, rf_ren, rf_addr, rf_wdata
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_wdata,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      output rf_rdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  rf_wen, rf_ren, rf_addr, rf_wdata
   );
endinterface

// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing one register-file port between two requesters,
// one transaction in flight: accept (IDLE) -> RF access (EXEC) -> response (RESP).
module rf_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input logic               clk,
   input logic               rst_n,
   rf_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              gnt0, gnt1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      id_d    = id_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state_q)
         IDLE: begin
            // last_q names the requester granted last; on a tie the other one wins
            if (bus.req0_valid && bus.req1_valid) begin
               gnt0 = last_q;
               gnt1 = !last_q;
            end else begin
               gnt0 = bus.req0_valid;
               gnt1 = bus.req1_valid;
            end
            if (gnt0 || gnt1) begin
               state_d = EXEC;
               last_d  = gnt1;
               id_d    = gnt1;
               we_d    = gnt1 ? bus.req1_we    : bus.req0_we;
               addr_d  = gnt1 ? bus.req1_addr  : bus.req0_addr;
               wdata_d = gnt1 ? bus.req1_wdata : bus.req0_wdata;
            end
         end
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.req0_ready = rst_n && gnt0;
   assign bus.req1_ready = rst_n && gnt1;

   // Entry 0 is read-only: writes to it complete but never reach the RF
   assign bus.rf_wen   = rst_n && (state_q == EXEC) && we_q && (addr_q != '0);
   assign bus.rf_ren   = rst_n && (state_q == EXEC) && !we_q;
   assign bus.rf_addr  = addr_q;
   assign bus.rf_wdata = wdata_q;

   assign bus.rsp0_valid = rst_n && (state_q == RESP) && !id_q;
   assign bus.rsp1_valid = rst_n && (state_q == RESP) && id_q;
   assign bus.rsp0_rdata = (bus.rsp0_valid && !we_q) ? bus.rf_rdata : '0;
   assign bus.rsp1_rdata = (bus.rsp1_valid && !we_q) ? bus.rf_rdata : '0;
endmodule
